// File: rtl/layer_compositor.sv
// Layer compositor: picks the highest-priority opaque layer, applies the
// game-over blink and hit-tint overlays, and drives blanked VGA colour.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   bright         display-area flag, aligned with layer inputs
//   frame_start    one-cycle pulse per frame
//   layer_en       per-layer pixel-on flags (index 0 = highest priority)
//   layer_rgb      flattened layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   game_over      level, selects the blinking game-over screen
//   hit_pulse      one-cycle pulse, starts or restarts the hit tint
//   rgb_out        final pixel colour (2-cycle latency)
//   top_idx        winning layer index, aligned with rgb_out
//   top_valid      1 when a layer won, aligned with rgb_out
module layer_compositor #(
   parameter int                 N_LAYERS       = 12,
   parameter int                 COLOR_W        = 12,
   parameter logic [COLOR_W-1:0] BG_COLOR       = 12'h69C,
   parameter logic [COLOR_W-1:0] GAMEOVER_COLOR = 12'h0F0,
   parameter bit                 KEY_EN         = 1'b1,
   parameter logic [COLOR_W-1:0] KEY_COLOR      = 12'hF0F,
   parameter int                 FLASH_FRAMES   = 30,
   parameter int                 HIT_FRAMES     = 20,
   localparam int                IDX_W          =
      (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         bright,
   input  logic                         frame_start,
   input  logic [N_LAYERS-1:0]          layer_en,
   input  logic [N_LAYERS*COLOR_W-1:0]  layer_rgb,
   input  logic                         game_over,
   input  logic                         hit_pulse,
   output logic [COLOR_W-1:0]           rgb_out,
   output logic [IDX_W-1:0]             top_idx,
   output logic                         top_valid
);

   localparam int CH_W    = COLOR_W / 3;
   localparam int HIT_W   =
      (HIT_FRAMES > 0) ? $clog2(HIT_FRAMES + 1) : 1;
   localparam int FL_W    =
      (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int FL_LAST =
      (FLASH_FRAMES > 0) ? FLASH_FRAMES - 1 : 0;

   // Stage 1 state
   logic [COLOR_W-1:0] sel_rgb_q, sel_rgb_d;
   logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
   logic               sel_valid_q, sel_valid_d;
   logic               bright_q, bright_d;

   // Overlay state
   logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
   logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;
   logic               phase_q, phase_d;
   logic               go_q, go_d;

   // Stage 2 / output state
   logic [COLOR_W-1:0] rgb_q, rgb_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;

   logic [N_LAYERS-1:0] opaque;
   logic                go_rise;
   logic                blink_on;
   logic [COLOR_W-1:0]  tinted;

   always_comb begin
      opaque = '0;
      for (int i = 0; i < N_LAYERS; i++) begin
         opaque[i] = layer_en[i] &&
            !(KEY_EN &&
              (layer_rgb[i*COLOR_W +: COLOR_W] == KEY_COLOR));
      end
   end

   // Scan from lowest priority upward so the lowest opaque index wins.
   always_comb begin
      sel_rgb_d   = BG_COLOR;
      sel_idx_d   = '0;
      sel_valid_d = 1'b0;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (opaque[i]) begin
            sel_rgb_d   = layer_rgb[i*COLOR_W +: COLOR_W];
            sel_idx_d   = IDX_W'(i);
            sel_valid_d = 1'b1;
         end
      end
      bright_d = bright;
   end

   assign go_rise = game_over && !go_q;

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (game_over) begin
         hit_cnt_d = '0;
      end else if (hit_pulse) begin
         hit_cnt_d = HIT_W'(HIT_FRAMES);
      end else if (frame_start && (hit_cnt_q != '0)) begin
         hit_cnt_d = hit_cnt_q - 1'b1;
      end
   end

   always_comb begin
      flash_cnt_d = flash_cnt_q;
      phase_d     = phase_q;
      go_d        = game_over;
      if (go_rise) begin
         flash_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (game_over && (FLASH_FRAMES > 0) && frame_start) begin
         if (flash_cnt_q == FL_W'(FL_LAST)) begin
            flash_cnt_d = '0;
            phase_d     = !phase_q;
         end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
         end
      end
   end

   // game_over is sampled live here, so its rising cycle must already
   // see the phase that the edge detector forces on.
   assign blink_on = go_rise || phase_q;

   always_comb begin
      tinted = sel_rgb_q;
      tinted[COLOR_W-1 -: CH_W] = '1;
   end

   always_comb begin
      rgb_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      if (!bright_q) begin
         rgb_d = '0;
      end else if (game_over) begin
         rgb_d = blink_on ? GAMEOVER_COLOR : BG_COLOR;
      end else if (hit_cnt_q != '0) begin
         rgb_d   = tinted;
         idx_d   = sel_idx_q;
         valid_d = sel_valid_q;
      end else begin
         rgb_d   = sel_rgb_q;
         idx_d   = sel_idx_q;
         valid_d = sel_valid_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_rgb_q   <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         bright_q    <= 1'b0;
         hit_cnt_q   <= '0;
         flash_cnt_q <= '0;
         phase_q     <= 1'b1;
         go_q        <= 1'b0;
         rgb_q       <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
      end else begin
         sel_rgb_q   <= sel_rgb_d;
         sel_idx_q   <= sel_idx_d;
         sel_valid_q <= sel_valid_d;
         bright_q    <= bright_d;
         hit_cnt_q   <= hit_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         phase_q     <= phase_d;
         go_q        <= go_d;
         rgb_q       <= rgb_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
      end
   end

   assign rgb_out   = rgb_q;
   assign top_idx   = idx_q;
   assign top_valid = valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: 4 layers, 2-frame blink, 3-frame hit tint.
// Expected pixels are queued at drive time and popped at output time.
module tb_layer_compositor;

   logic        clk;
   logic        reset_n;
   logic        bright;
   logic        frame_start;
   logic [3:0]  layer_en;
   logic [47:0] layer_rgb;
   logic        game_over;
   logic        hit_pulse;
   logic [11:0] rgb_out;
   logic [1:0]  top_idx;
   logic        top_valid;

   typedef struct packed {
      logic [11:0] rgb;
      logic [1:0]  idx;
      logic        valid;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks;
   int   errors;

   layer_compositor #(
      .N_LAYERS     (4),
      .COLOR_W      (12),
      .FLASH_FRAMES (2),
      .HIT_FRAMES   (3)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bright      (bright),
      .frame_start (frame_start),
      .layer_en    (layer_en),
      .layer_rgb   (layer_rgb),
      .game_over   (game_over),
      .hit_pulse   (hit_pulse),
      .rgb_out     (rgb_out),
      .top_idx     (top_idx),
      .top_valid   (top_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic pulse_hit();
      hit_pulse = 1'b1;
      tick(1);
      hit_pulse = 1'b0;
   endtask

   task automatic set_layers(input logic [3:0] en,
                             input logic [11:0] c0,
                             input logic [11:0] c1,
                             input logic [11:0] c2,
                             input logic [11:0] c3);
      layer_en  = en;
      layer_rgb = {c3, c2, c1, c0};
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      bright      = 1'b0;
      frame_start = 1'b0;
      game_over   = 1'b0;
      hit_pulse   = 1'b0;
      set_layers(4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
      tick(3);
      sb.push_back(exp_t'{12'h000, 2'd0, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL reset got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_priority();
      set_layers(4'b1010, 12'h000, 12'h123, 12'h000, 12'h456);
      bright = 1'b1;
      sb.push_back(exp_t'{12'h123, 2'd1, 1'b1});
      tick(1);
      checks++;
      if (rgb_out !== 12'h000) begin
         errors++;
         $display("FAIL latency1 got %h exp 000", rgb_out);
      end
      tick(1);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL prio got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      bright = 1'b0;
      sb.push_back(exp_t'{12'h000, 2'd0, 1'b0});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL blank got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
   endtask

   task automatic test_key();
      logic [3:0]  en_t [3];
      logic [11:0] c0_t [3];
      exp_t        ex_t [3];
      en_t[0] = 4'b0011; c0_t[0] = 12'hF0F;
      ex_t[0] = exp_t'{12'hABC, 2'd1, 1'b1};
      en_t[1] = 4'b0000; c0_t[1] = 12'hABC;
      ex_t[1] = exp_t'{12'h69C, 2'd0, 1'b0};
      en_t[2] = 4'b1001; c0_t[2] = 12'hABC;
      ex_t[2] = exp_t'{12'hABC, 2'd0, 1'b1};
      bright = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_layers(en_t[k], c0_t[k], 12'hABC, 12'h000, 12'h777);
         sb.push_back(ex_t[k]);
         tick(2);
         e = sb.pop_front();
         checks++;
         if ({rgb_out, top_idx, top_valid} !== e) begin
            errors++;
            $display("FAIL key%0d got %h/%0d/%b exp %h/%0d/%b", k,
                     rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
         end
      end
   endtask

   task automatic test_flash();
      logic [11:0] seq [6];
      seq[0] = 12'h0F0; seq[1] = 12'h0F0; seq[2] = 12'h69C;
      seq[3] = 12'h69C; seq[4] = 12'h0F0; seq[5] = 12'h0F0;
      set_layers(4'b0001, 12'h123, 12'h000, 12'h000, 12'h000);
      bright    = 1'b1;
      game_over = 1'b1;
      tick(2);
      for (int k = 0; k < 6; k++) begin
         sb.push_back(exp_t'{seq[k], 2'd0, 1'b0});
         e = sb.pop_front();
         checks++;
         if ({rgb_out, top_idx, top_valid} !== e) begin
            errors++;
            $display("FAIL flash%0d got %h/%0d/%b exp %h/%0d/%b", k,
                     rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
         end
         pulse_fs();
         tick(2);
      end
      bright = 1'b0;
      sb.push_back(exp_t'{12'h000, 2'd0, 1'b0});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL flash_blank got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      game_over = 1'b0;
      bright    = 1'b1;
      sb.push_back(exp_t'{12'h123, 2'd0, 1'b1});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL flash_exit got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
   endtask

   // Steps: 0 = hit, 1 = frame, 2 = hit together with frame.
   task automatic test_hit();
      int          op [9];
      logic [11:0] ex [9];
      op[0] = 0; ex[0] = 12'hF23;
      op[1] = 1; ex[1] = 12'hF23;
      op[2] = 1; ex[2] = 12'hF23;
      op[3] = 1; ex[3] = 12'h123;
      op[4] = 0; ex[4] = 12'hF23;
      op[5] = 1; ex[5] = 12'hF23;
      op[6] = 2; ex[6] = 12'hF23;
      op[7] = 1; ex[7] = 12'hF23;
      op[8] = 1; ex[8] = 12'hF23;
      set_layers(4'b0001, 12'h123, 12'h000, 12'h000, 12'h000);
      bright = 1'b1;
      for (int k = 0; k < 9; k++) begin
         hit_pulse   = (op[k] != 1);
         frame_start = (op[k] != 0);
         tick(1);
         hit_pulse   = 1'b0;
         frame_start = 1'b0;
         sb.push_back(exp_t'{ex[k], 2'd0, 1'b1});
         tick(2);
         e = sb.pop_front();
         checks++;
         if ({rgb_out, top_idx, top_valid} !== e) begin
            errors++;
            $display("FAIL hit%0d got %h/%0d/%b exp %h/%0d/%b", k,
                     rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
         end
      end
      pulse_fs();
      sb.push_back(exp_t'{12'h123, 2'd0, 1'b1});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL hit_end got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
   endtask

   task automatic test_go_clears_hit();
      pulse_hit();
      pulse_fs();
      game_over = 1'b1;
      sb.push_back(exp_t'{12'h0F0, 2'd0, 1'b0});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL go_rise got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      pulse_hit();
      game_over = 1'b0;
      sb.push_back(exp_t'{12'h123, 2'd0, 1'b1});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL go_clear got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
   endtask

   task automatic test_reset_mid();
      game_over = 1'b1;
      tick(2);
      pulse_fs();
      pulse_fs();
      sb.push_back(exp_t'{12'h69C, 2'd0, 1'b0});
      tick(2);
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL pre_rst got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      sb.push_back(exp_t'{12'h000, 2'd0, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({rgb_out, top_idx, top_valid} !== e) begin
         errors++;
         $display("FAIL async_rst got %h/%0d/%b exp %h/%0d/%b",
                  rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
      end
      tick(2);
      reset_n = 1'b1;
      sb.push_back(exp_t'{12'h000, 2'd0, 1'b0});
      sb.push_back(exp_t'{12'h0F0, 2'd0, 1'b0});
      for (int k = 0; k < 2; k++) begin
         tick(1);
         e = sb.pop_front();
         checks++;
         if ({rgb_out, top_idx, top_valid} !== e) begin
            errors++;
            $display("FAIL post_rst%0d got %h/%0d/%b exp %h/%0d/%b", k,
                     rgb_out, top_idx, top_valid, e.rgb, e.idx, e.valid);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_priority();
      test_key();
      test_flash();
      test_hit();
      test_go_clears_hit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
